// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM receive path: duty width, divider length
// and the capture FSM state encoding.
package pwm_pkg;

  localparam int DUTY_W    = 8;
  localparam int DIV_STEPS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } pwm_cap_state_t;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring unsigned divider producing floor(num*256/den), one quotient bit
// per clock, MSB first. The first step is taken in the start cycle itself.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num,
  input  logic [CNT_W-1:0]  den,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] quot
);

  localparam int RW = CNT_W + 1;
  localparam int SW = $clog2(DIV_STEPS + 1);

  logic [RW-1:0]     rem_q, rem_d, src_rem, shl;
  logic [CNT_W-1:0]  den_q, src_den;
  logic [DUTY_W-1:0] quot_q;
  logic [SW-1:0]     cnt_q;
  logic              done_q, qbit;

  // num < den keeps the remainder below 2^CNT_W, so the shift never loses its top bit.
  always_comb begin
    src_rem = start ? {1'b0, num} : rem_q;
    src_den = start ? den : den_q;
    shl     = {src_rem[RW-2:0], 1'b0};
    qbit    = (shl >= {1'b0, src_den});
    rem_d   = qbit ? (shl - {1'b0, src_den}) : shl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      den_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q  <= rem_d;
      den_q  <= den;
      quot_q <= {{(DUTY_W-1){1'b0}}, qbit};
      cnt_q  <= SW'(DIV_STEPS - 1);
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      rem_q  <= rem_d;
      quot_q <= {quot_q[DUTY_W-2:0], qbit};
      cnt_q  <= cnt_q - SW'(1);
      done_q <= (cnt_q == SW'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy = (cnt_q != '0);
  assign done = done_q;
  assign quot = quot_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time between rising edges and
// reports an 8-bit duty cycle, with stuck-input and overrun detection.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              pwm_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic [CNT_W-1:0]  period_o,
  output logic [CNT_W-1:0]  high_o,
  output logic              valid_o,
  output logic              stuck_o,
  output logic              overrun_o
);

  localparam logic [CNT_W-1:0] ONES = '1;

  logic              sync1_q, sync2_q, prev_q, rise;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d, hcnt_q, hcnt_d, shp_q, shh_q;
  pwm_cap_state_t    state_q, state_d;
  logic              latch, div_start, load_res, load_stuck, set_ovr;
  logic              div_busy, div_done;
  logic [DUTY_W-1:0] div_quot;
  logic [DUTY_W-1:0] duty_q;
  logic [CNT_W-1:0]  period_q, high_q;
  logic              valid_q, stuck_q, overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= pwm_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

  // Both counters restart at 1 on the edge so that at the next edge they hold
  // exactly the period and high time of the cycle just ended.
  always_comb begin
    pcnt_d = pcnt_q;
    hcnt_d = hcnt_q;
    if (!ena) begin
      pcnt_d = '0;
      hcnt_d = '0;
    end else if (rise) begin
      pcnt_d = CNT_W'(1);
      hcnt_d = CNT_W'(1);
    end else begin
      if (pcnt_q != ONES)            pcnt_d = pcnt_q + CNT_W'(1);
      if (sync2_q && hcnt_q != ONES) hcnt_d = hcnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    latch      = 1'b0;
    div_start  = 1'b0;
    load_res   = 1'b0;
    load_stuck = 1'b0;
    set_ovr    = 1'b0;
    case (state_q)
      IDLE: if (rise) state_d = MEAS;
      MEAS: begin
        if (rise) begin
          latch     = 1'b1;
          div_start = 1'b1;
          state_d   = DIV;
        end else if (pcnt_q == ONES) begin
          load_stuck = 1'b1;
          state_d    = IDLE;
        end
      end
      DIV: begin
        set_ovr = rise;
        if (div_done) begin
          load_res = 1'b1;
          state_d  = DONE;
        end else if (!div_busy) begin
          // divider idle without a result: fall back to measuring
          state_d = MEAS;
        end
      end
      DONE: begin
        if (rise) begin
          latch     = 1'b1;
          div_start = 1'b1;
          state_d   = DIV;
        end else begin
          state_d = MEAS;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!ena) begin
      state_d    = IDLE;
      latch      = 1'b0;
      div_start  = 1'b0;
      load_res   = 1'b0;
      load_stuck = 1'b0;
      set_ovr    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      shp_q   <= '0;
      shh_q   <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      if (latch) begin
        shp_q <= pcnt_q;
        shh_q <= hcnt_q;
      end
    end
  end

  pwm_duty_div #(.CNT_W(CNT_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (hcnt_q),
    .den   (pcnt_q),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  // Results are loaded on the way into DONE so they are visible with valid_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      stuck_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= load_res | load_stuck;
      if (!ena)         overrun_q <= 1'b0;
      else if (set_ovr) overrun_q <= 1'b1;
      if (load_res) begin
        duty_q   <= div_quot;
        period_q <= shp_q;
        high_q   <= shh_q;
        stuck_q  <= 1'b0;
      end else if (load_stuck) begin
        duty_q   <= {DUTY_W{sync2_q}};
        period_q <= ONES;
        high_q   <= sync2_q ? ONES : '0;
        stuck_q  <= 1'b1;
      end
    end
  end

  assign duty_o    = duty_q;
  assign period_o  = period_q;
  assign high_o    = high_q;
  assign valid_o   = valid_q;
  assign stuck_o   = stuck_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table vectors, random periods against an arithmetic
// scoreboard, and hand sequences for stuck, overrun and mid-divide aborts.
module tb_pwm_capture;

  localparam int CNT_W = 8;
  localparam int ONES  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, ena, pwm_i;
  logic [7:0]       duty_o;
  logic [CNT_W-1:0] period_o, high_o;
  logic             valid_o, stuck_o, overrun_o;

  pwm_capture #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .pwm_i     (pwm_i),
    .duty_o    (duty_o),
    .period_o  (period_o),
    .high_o    (high_o),
    .valid_o   (valid_o),
    .stuck_o   (stuck_o),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct { int p; int h; } res_t;
  typedef struct { int p; int h; int duty; } vec_t;

  res_t exp_q[$];
  res_t mon_e;
  vec_t tbl[8];
  int   n_pass = 0, n_total = 0, vcount = 0;
  bit   mon_en = 1'b0, have_prev = 1'b0;
  int   prev_p = 0, prev_h = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Scoreboard: every reported period must match the oldest completed one.
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      vcount++;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected valid (queue size)", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb period", int'(period_o), mon_e.p);
          chk("sb high",   int'(high_o),   mon_e.h);
          chk("sb duty",   int'(duty_o),   (256 * mon_e.h) / mon_e.p);
          chk("sb stuck",  int'(stuck_o),  0);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One PWM period starting with a rising edge; a new edge closes the previous period.
  task automatic run_period(input int p, input int h, output int first_v);
    res_t r;
    first_v = -1;
    if (mon_en && have_prev) begin
      r.p = prev_p;
      r.h = prev_h;
      exp_q.push_back(r);
    end
    pwm_i = 1'b1;
    for (int k = 1; k <= p; k++) begin
      @(posedge clk); #1;
      if (k == h) pwm_i = 1'b0;
      if (valid_o && first_v < 0) first_v = k;
    end
    prev_p = p;
    prev_h = h;
    have_prev = 1'b1;
  endtask

  task automatic finish_phase();
    int fv;
    run_period(20, 3, fv);
    chk("scoreboard drained", exp_q.size(), 0);
    ena = 1'b0;
    wait_cycles(1);
    ena = 1'b1;
    have_prev = 1'b0;
  endtask

  // Rising edge, hold high for h clocks (h > n means never falls), watch n clocks.
  task automatic hold_watch(input int h, input int n, output int lat, output int nv);
    lat = -1;
    nv  = 0;
    pwm_i = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == h) pwm_i = 1'b0;
      if (valid_o) begin
        nv++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  // Edge detected 2 clocks after the drive, so clock 6 is the 4th DIV cycle.
  task automatic abort_div(input bit use_rst, output int nv);
    nv = 0;
    pwm_i = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 6) begin
        if (use_rst) begin
          rst_n = 1'b0;
          #1;
          chk("rst abort valid",   int'(valid_o),   0);
          chk("rst abort duty",    int'(duty_o),    0);
          chk("rst abort period",  int'(period_o),  0);
          chk("rst abort high",    int'(high_o),    0);
          chk("rst abort stuck",   int'(stuck_o),   0);
          chk("rst abort overrun", int'(overrun_o), 0);
        end else begin
          ena = 1'b0;
        end
      end
      if (k == 8 && use_rst) rst_n = 1'b1;
      if (k == 25) pwm_i = 1'b0;
      if (valid_o) nv++;
    end
    ena = 1'b1;
  endtask

  initial begin
    int fv, lat, nv, p, h;

    tbl[0] = '{100, 25, 64};
    tbl[1] = '{100, 99, 253};
    tbl[2] = '{9, 4, 113};
    tbl[3] = '{200, 1, 1};
    tbl[4] = '{250, 125, 128};
    tbl[5] = '{10, 9, 230};
    tbl[6] = '{254, 253, 254};
    tbl[7] = '{77, 33, 109};

    rst_n = 1'b0;
    ena   = 1'b1;
    pwm_i = 1'b0;
    repeat (8) begin @(posedge clk); #1; pwm_i = ~pwm_i; end
    chk("reset valid",   int'(valid_o),   0);
    chk("reset duty",    int'(duty_o),    0);
    chk("reset period",  int'(period_o),  0);
    chk("reset high",    int'(high_o),    0);
    chk("reset stuck",   int'(stuck_o),   0);
    chk("reset overrun", int'(overrun_o), 0);
    pwm_i = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(3);

    mon_en = 1'b1;
    run_period(100, 25, fv);
    chk("no valid for first partial period", vcount, 0);
    run_period(100, 25, fv);
    chk("valid latency from pwm edge", fv, 11);

    for (int i = 0; i < 8; i++) begin
      repeat (4) run_period(tbl[i].p, tbl[i].h, fv);
      chk($sformatf("tbl[%0d] duty", i),   int'(duty_o),   tbl[i].duty);
      chk($sformatf("tbl[%0d] period", i), int'(period_o), tbl[i].p);
      chk($sformatf("tbl[%0d] high", i),   int'(high_o),   tbl[i].h);
    end
    chk("no overrun at period >= 9", int'(overrun_o), 0);
    finish_phase();

    for (int i = 0; i < 20; i++) begin
      p = int'($urandom_range(200, 9));
      h = int'($urandom_range(p - 1, 1));
      run_period(p, h, fv);
    end
    finish_phase();
    mon_en = 1'b0;

    nv = vcount;
    hold_watch(100000, 300, lat, fv);
    chk("stuck-high valid latency", lat, (1 << CNT_W) + 2);
    chk("stuck-high single valid",  fv, 1);
    chk("stuck-high stuck",  int'(stuck_o),  1);
    chk("stuck-high duty",   int'(duty_o),   255);
    chk("stuck-high high",   int'(high_o),   ONES);
    chk("stuck-high period", int'(period_o), ONES);
    wait_cycles(300);
    chk("stuck-high no repeat valid", vcount - nv, 1);

    pwm_i = 1'b0;
    wait_cycles(4);
    hold_watch(3, 300, lat, fv);
    chk("stuck-low valid latency", lat, (1 << CNT_W) + 2);
    chk("stuck-low single valid",  fv, 1);
    chk("stuck-low stuck", int'(stuck_o), 1);
    chk("stuck-low duty",  int'(duty_o),  0);
    chk("stuck-low high",  int'(high_o),  0);

    mon_en = 1'b1;
    have_prev = 1'b0;
    run_period(50, 20, fv);
    run_period(50, 20, fv);
    finish_phase();
    chk("stuck cleared by valid period", int'(stuck_o), 0);
    chk("duty after stuck clears", int'(duty_o), 102);
    mon_en = 1'b0;

    chk("overrun clear before short periods", int'(overrun_o), 0);
    repeat (6) run_period(5, 2, fv);
    chk("overrun set by period 5", int'(overrun_o), 1);
    repeat (4) run_period(9, 4, fv);
    chk("overrun sticky", int'(overrun_o), 1);

    repeat (3) run_period(100, 25, fv);
    chk("pre-ena-abort duty", int'(duty_o), 64);
    abort_div(1'b0, nv);
    chk("ena abort no valid", nv, 0);
    chk("ena abort duty held",   int'(duty_o),   64);
    chk("ena abort period held", int'(period_o), 100);
    chk("ena abort high held",   int'(high_o),   25);
    chk("ena abort overrun cleared", int'(overrun_o), 0);

    repeat (2) run_period(100, 25, fv);
    chk("pre-reset-abort period", int'(period_o), 100);
    abort_div(1'b1, nv);
    chk("rst abort no valid", nv, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its period, high time and 8-bit duty cycle. The 8-bit duty cycle uses the same scale as the team's PWM generator: duty = 256·high/period. The block is the receive side of the PWM link. It sits between an external PWM pin and the user logic of the tile. Each rising edge of the input completes one measurement, and a one-cycle `valid_o` pulse announces the new result.

## Interface
- `CNT_W`, default 24: width of the period and high-time counters. 24 bits covers the generator's slowest period of 2,667,008 clocks.
- `clk` input 1: single clock for the whole block.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: block enable. When 0, the FSM returns synchronously to IDLE, the counters clear and the outputs hold.
- `pwm_i` input 1: PWM input, asynchronous to `clk`.
- `duty_o` output 8: floor(high·256/period); 0 or 255 when stuck.
- `period_o` output CNT_W: clocks from one rising edge to the next.
- `high_o` output CNT_W: clocks the input was high within that period.
- `valid_o` output 1: one-cycle pulse; the outputs above update in the same cycle.
- `stuck_o` output 1: no rising edge seen within 2^CNT_W−1 clocks.
- `overrun_o` output 1: sticky flag; a period ended while the divider was busy and was dropped.

## Operation
- **Input conditioning**
  - `pwm_i` passes through a 2-flop synchronizer; both flops reset to 0.
  - A third flop holds the previous synchronized level.
  - `rise` = synced & ~prev; this is the edge-detect cycle.
- **Counters** run in every state while `ena`=1:
  - On `rise`: `pcnt`←1 and `hcnt`←1.
  - Otherwise: `pcnt` increments, saturating at all-ones. `hcnt` increments when synced=1.
  - high ≤ period−1 always holds, so the quotient is below 256.
- **FSM states: IDLE, MEAS, DIV, DONE.**
  - IDLE: wait for `rise`, then go to MEAS. The first partial period is never reported.
  - MEAS, on `rise`:
    - Latch `pcnt` and `hcnt` into the shadow registers before the counters restart.
    - Start the divider and go to DIV.
  - MEAS, on `pcnt` saturating:
    - Set `stuck_o`=1 and `duty_o` = synced ? 255 : 0.
    - Set `period_o` = all-ones and `high_o` = synced ? all-ones : 0.
    - Pulse `valid_o` once and go to IDLE.
  - DIV: 8 cycles, then DONE.
    - A `rise` during DIV is counted normally, but its period is discarded and `overrun_o` is set.
  - DONE, one cycle:
    - Pulse `valid_o`, load `duty_o`, `period_o` and `high_o` from the result, and clear `stuck_o`.
    - If `rise` occurs in DONE, latch the new period and go straight to DIV; no overrun.
    - Otherwise go to MEAS.
- **Divider** (restoring, unsigned):
  - rem = high, CNT_W+1 bits.
  - Each step: rem←rem<<1; if rem ≥ period then rem −= period and quotient bit = 1, else 0.
  - Quotient bits are produced MSB first.
- `overrun_o` clears only on reset or when `ena`=0.

## Timing
- Reset value of every output: 0.
- Input to `rise` latency: 2–3 clocks from `pwm_i` edge.
- The edge-detect cycle is N. The shadow registers are loaded at N; DIV covers N+1..N+8; `valid_o`=1 and the outputs update at N+9.
- Minimum period without overrun: 9 clocks.
- Stuck detection: `valid_o` is asserted in the cycle after `pcnt` reaches 2^CNT_W−1.
- Reset mid-DIV: every output and state returns to 0 or IDLE immediately, and no `valid_o` is issued.
- `ena` falling mid-DIV: the result is abandoned, no `valid_o` is issued, and the outputs keep their last values.

## Structure
- Shared package `pwm_pkg`:
  - `DUTY_W` = 8.
  - FSM state enum `pwm_cap_state_t` (IDLE, MEAS, DIV, DONE).
  - `DIV_STEPS` = 8.
- Sub-module `pwm_duty_div`:
  - Ports: `start`, `num[CNT_W-1:0]`, `den[CNT_W-1:0]`, `busy`, `done`, `quot[7:0]`.
  - Contains the step counter and the remainder register.
- The top level holds the synchronizer, counters, shadow registers, FSM and output registers.

## Test plan
- Reset: hold `rst_n`=0 while `pwm_i` toggles → all outputs 0 and no `valid_o` after release until the second rising edge.
- Period 100, high 25, repeated → each result: `period_o`=100, `high_o`=25, `duty_o`=64; `valid_o` at edge-detect+9; exactly one pulse per period.
- Period 100, high 99 → `duty_o`=253. Period 256·10418, high 128·10418 → `duty_o`=128.
- CNT_W=8, `pwm_i` held 1 after one rising edge → `stuck_o`=1, `duty_o`=255, `high_o`=255, a single `valid_o`. Repeat with `pwm_i` held 0 → `duty_o`=0. The next valid period clears `stuck_o`.
- Period 5, high 2 → `overrun_o`=1 and stays set. Period 9 → `overrun_o` never set and a result every period.
- Assert `rst_n`=0 at N+4 of a DIV → outputs 0 immediately and no `valid_o`. Drop `ena` mid-DIV → outputs unchanged, no `valid_o`, and `overrun_o` cleared.
